reg_fifo: RTL

- Parametrised register-based FIFO. It generalises the fixed-width single registers (8/9/32-bit) to any width and depth, and adds flow control.
- Buffers operands and results between stages of the floating-point multiplier datapath, e.g. sign/exponent/mantissa packets between unpack, multiply and normalise.
- First-word-fall-through (FWFT): the head word is visible on data_out whenever the FIFO is not empty.

---
 rtl/reg_fifo_if.sv | 37 +++
 rtl/reg_fifo.sv | 98 +++++++++
 2 files changed

// File: rtl/reg_fifo_if.sv
// Handshake/data bundle for reg_fifo. almost_full exists only when
// REG_FIFO_ALMOST_FULL_EN is defined.
interface reg_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef REG_FIFO_ALMOST_FULL_EN
  logic             almost_full;
`endif

  modport master (
    output flush, wr_en, data_in, rd_en,
`ifdef REG_FIFO_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
`ifdef REG_FIFO_ALMOST_FULL_EN
    output almost_full,
`endif
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/reg_fifo.sv
// Register-based first-word-fall-through FIFO with sticky overflow/underflow flags.
// Optional almost_full output enabled by defining REG_FIFO_ALMOST_FULL_EN.
module reg_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4
`ifdef REG_FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_LEVEL = DEPTH - 1
`endif
) (
  input  logic     clk,
  input  logic     reset,
  reg_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty;
  logic             wr_accept, rd_accept;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO may still take a write when the head is popped the same cycle.
  assign wr_accept = bus.wr_en && (!full || bus.rd_en);
  assign rd_accept = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.wr_en && full && !bus.rd_en) overflow_d  = 1'b1;
      if (bus.rd_en && empty)              underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flush leaves storage intact; the emptied count masks it on data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_accept && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`ifdef REG_FIFO_ALMOST_FULL_EN
  assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
`endif

endmodule
